// File: rtl/cache_response_packer_pkg.sv
// Shared types for the cache response packer: memory packets, IOB
// cache bundles, FIFO status and the packer's own state/pending types.
package cache_response_packer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int FIELDS = 4;
  localparam int ID_W   = 4;
  localparam int HOPS_W = 4;
  localparam int SEQ_W  = 8;

  typedef enum logic [2:0] {
    CMD_INVALID      = 3'd0,
    CMD_MEM_READ     = 3'd1,
    CMD_MEM_WRITE    = 3'd2,
    CMD_MEM_RESPONSE = 3'd3
  } type_memory_cmd;

  typedef struct packed {
    logic [ID_W-1:0] id_cu;
    logic [ID_W-1:0] id_bundle;
    logic [ID_W-1:0] id_lane;
  } MemoryPacketRouteAddress;

  typedef struct packed {
    MemoryPacketRouteAddress from;
    MemoryPacketRouteAddress to;
    logic [HOPS_W-1:0]       hops;
  } MemoryPacketRouteAttributes;

  typedef struct packed {
    logic [ID_W-1:0]  seq_src;
    logic [SEQ_W-1:0] seq_id;
    logic [1:0]       seq_state;
  } MemoryPacketSequence;

  typedef struct packed {
    type_memory_cmd cmd;
    logic [1:0]     buffer;
  } MemoryPacketSubclass;

  typedef struct packed {
    MemoryPacketRouteAttributes route;
    MemoryPacketSequence        seq;
    logic [ADDR_W-1:0]          address;
    MemoryPacketSubclass        subclass;
  } MemoryPacketMeta;

  typedef struct packed {
    logic [FIELDS-1:0][DATA_W-1:0] field;
  } MemoryPacketData;

  typedef struct packed {
    MemoryPacketMeta meta;
    MemoryPacketData data;
  } MemoryPacketPayload;

  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacket;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } CacheRequestIOB;

  typedef struct packed {
    CacheRequestIOB  iob;
    MemoryPacketMeta meta;
    MemoryPacketData data;
  } CacheRequestPayload;

  typedef struct packed {
    logic               valid;
    CacheRequestPayload payload;
  } CacheRequest;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] rdata;
  } CacheResponseIOB;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
  } FIFOStateSignalsOutput;

  typedef enum logic [2:0] {
    IDLE       = 3'b001,
    ISSUE      = 3'b010,
    WAIT_CACHE = 3'b100
  } type_response_packer_state;

  typedef struct packed {
    MemoryPacketMeta meta;
    MemoryPacketData data;
    logic            is_write;
  } ResponsePackerPending;

  function automatic logic [HOPS_W-1:0] hops_inc(
    input logic [HOPS_W-1:0] h
  );
    return (&h) ? h : h + 1'b1;
  endfunction

endpackage

// File: rtl/response_packer_fifo.sv
// First-word-fall-through synchronous FIFO used for pending metadata
// and for the repacked response buffer.
module response_packer_fifo
  import cache_response_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      din_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      dout_o,
  output FIFOStateSignalsOutput signals_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] PF_LVL   = (PTR_W+1)'(DEPTH - 2);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full, empty, wr_en, rd_en;

  assign full  = (cnt_q == FULL_LVL);
  assign empty = (cnt_q == '0);
  assign wr_en = push_i && !full;
  assign rd_en = pop_i && !empty;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end

  assign dout_o              = mem_q[rd_q];
  assign signals_o.full      = full;
  assign signals_o.empty     = empty;
  assign signals_o.valid     = !empty;
  assign signals_o.prog_full = (cnt_q >= PF_LVL);

endmodule

// File: rtl/cache_response_packer.sv
// Forwards CacheRequests to the blocking IOB cache and repacks each completion
// into a CMD_MEM_RESPONSE MemoryPacket. Option: RESPONSE_HOPS_INC_EN.
module cache_response_packer
  import cache_response_packer_pkg::*;
#(
  parameter  int PENDING_DEPTH = 16,
  localparam int COUNT_W       = $clog2(PENDING_DEPTH) + 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  CacheRequest           request_in,
  output logic                  request_in_ready,
  output CacheRequestIOB        cache_request_out,
  input  CacheResponseIOB       cache_response_in,
  output MemoryPacket           response_out,
  input  logic                  response_out_ready,
  output FIFOStateSignalsOutput fifo_response_signals_out,
  output logic                  done_out
`ifdef RESPONSE_HOPS_INC_EN
  ,
  output logic                  protocol_error_out
`endif
);

  localparam int PEND_W = $bits(ResponsePackerPending);
  localparam int RSP_W  = $bits(MemoryPacketPayload);
  localparam logic [COUNT_W-1:0] CREDIT_MAX = COUNT_W'(PENDING_DEPTH);

  type_response_packer_state state_q, state_d;
  CacheRequestIOB            req_q, req_d;
  logic [COUNT_W-1:0]        credit_q, credit_d;
  logic [1:0]                arm_q;
  logic                      rsp_v_q;
  logic [DATA_W-1:0]         rdata_q;

  logic                  accept, drain, cache_done;
  ResponsePackerPending  pend_in, pend_out;
  logic [PEND_W-1:0]     pend_out_w;
  MemoryPacketPayload    rsp_in;
  logic [RSP_W-1:0]      rsp_head_w;
  FIFOStateSignalsOutput meta_sig, rsp_sig;

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    request_in_ready = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        request_in_ready = arm_q[1] && (credit_q != '0);
        if (request_in.valid && request_in_ready) begin
          req_d       = request_in.payload.iob;
          req_d.valid = 1'b0;
          state_d     = ISSUE;
        end
      end
      (state_q == ISSUE): begin
        req_d.valid = 1'b1;
        state_d     = WAIT_CACHE;
      end
      (state_q == WAIT_CACHE): begin
        if (cache_response_in.ready) begin
          req_d.valid = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept     = request_in.valid && request_in_ready;
  assign drain      = response_out.valid && response_out_ready;
  assign cache_done = (state_q == WAIT_CACHE) && cache_response_in.ready;

  always_comb begin
    credit_d = credit_q;
    if (accept && !drain) begin
      credit_d = credit_q - 1'b1;
    end else if (!accept && drain) begin
      credit_d = credit_q + 1'b1;
    end
  end

  // arm_q delays request_in_ready until two edges after reset release
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      credit_q <= CREDIT_MAX;
      arm_q    <= '0;
      rsp_v_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      credit_q <= credit_d;
      arm_q    <= {arm_q[0], 1'b1};
      rsp_v_q  <= cache_done;
      if (cache_done) rdata_q <= cache_response_in.rdata;
    end
  end

  assign pend_in.meta     = request_in.payload.meta;
  assign pend_in.data     = request_in.payload.data;
  assign pend_in.is_write = |request_in.payload.iob.wstrb;
  assign pend_out         = ResponsePackerPending'(pend_out_w);

  response_packer_fifo #(
    .WIDTH(PEND_W),
    .DEPTH(2)
  ) u_meta_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .push_i   (accept),
    .din_i    (pend_in),
    .pop_i    (rsp_v_q),
    .dout_o   (pend_out_w),
    .signals_o(meta_sig)
  );

  // wdata still sits in req_q during the repack cycle: acts as write ack
  always_comb begin
    rsp_in                   = '0;
    rsp_in.meta              = pend_out.meta;
    rsp_in.meta.route.from   = pend_out.meta.route.to;
    rsp_in.meta.route.to     = pend_out.meta.route.from;
`ifdef RESPONSE_HOPS_INC_EN
    rsp_in.meta.route.hops   = hops_inc(pend_out.meta.route.hops);
`endif
    rsp_in.meta.subclass.cmd = CMD_MEM_RESPONSE;
    rsp_in.data              = pend_out.data;
    rsp_in.data.field[0]     = pend_out.is_write ? req_q.wdata : rdata_q;
  end

  response_packer_fifo #(
    .WIDTH(RSP_W),
    .DEPTH(PENDING_DEPTH)
  ) u_rsp_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .push_i   (rsp_v_q),
    .din_i    (rsp_in),
    .pop_i    (drain),
    .dout_o   (rsp_head_w),
    .signals_o(rsp_sig)
  );

  assign response_out.valid   = !rsp_sig.empty;
  assign response_out.payload = MemoryPacketPayload'(rsp_head_w);
  assign cache_request_out    = req_q;

  assign fifo_response_signals_out.full      = (credit_q == '0);
  assign fifo_response_signals_out.empty     = rsp_sig.empty;
  assign fifo_response_signals_out.valid     = response_out.valid;
  assign fifo_response_signals_out.prog_full = (credit_q <= COUNT_W'(2));

  assign done_out = (credit_q == CREDIT_MAX) && (state_q == IDLE);

`ifdef RESPONSE_HOPS_INC_EN
  logic err_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_q <= 1'b0;
    end else if (cache_response_in.ready && (state_q != WAIT_CACHE)) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_error_out = err_q;
`endif

  logic unused_sig;
  assign unused_sig = ^{meta_sig, rsp_sig.full, rsp_sig.valid,
                        rsp_sig.prog_full};

endmodule

// File: doc/cache_response_packer.md
Name: cache_response_packer

Overview:
- Responder-side companion to the memory request path.
- Accepts CacheRequest packets bound for the IOB cache frontend and forwards them to the cache.
- Holds each request's MemoryPacketMeta while the cache is busy with it.
- Repacks every cache completion (iob.ready + rdata) into a MemoryPacket with cmd = CMD_MEM_RESPONSE, routed back to the requester.
- Sits between a bundle's cache frontend and the lane/engine response network; a credit counter makes sure a cache completion is never dropped.

Parameters:
- PENDING_DEPTH, 16: max requests in flight plus responses buffered; power of 2, 2..64.
- COUNT_W, $clog2(PENDING_DEPTH)+1: credit counter width (derived, not overridden).

Ports:
- ap_clk  in  1  block clock
- ap_rst_n  in  1  asynchronous active-low reset
- request_in  in  CacheRequest  request from the request generator; payload.iob.wstrb != 0 marks a write
- request_in_ready  out  1  request accepted this cycle when request_in.valid && request_in_ready
- cache_request_out  out  CacheRequestIOB  IOB request to the cache; valid is held until completion
- cache_response_in  in  CacheResponseIOB  cache completion; ready is a 1-cycle strobe; rdata is valid with ready
- response_out  out  MemoryPacket  repacked response
- response_out_ready  in  1  downstream accepts response_out when valid && ready
- fifo_response_signals_out  out  FIFOStateSignalsOutput  state of the response buffer
- done_out  out  1  high when nothing is in flight and nothing is buffered

Behaviour:
- Reset (async assert, sync deassert):
  - request_in_ready = 0, cache_request_out.valid = 0, response_out.valid = 0, done_out = 1.
  - Credit = PENDING_DEPTH; FIFOs empty (empty = 1, full = 0).
  - request_in_ready rises on the 2nd cycle after deassert.
- Reset mid-operation discards every in-flight meta and buffered response. The cache is assumed reset alongside this block.
- State machine: IDLE -> ISSUE -> WAIT_CACHE -> IDLE.
  - IDLE: request_in_ready = 1 when credit > 0. On accept, latch iob into the cache_request_out register, push {meta, data, is_write} to the meta FIFO, decrement credit, go to ISSUE.
  - ISSUE: cache_request_out.valid = 1 from the next cycle; go to WAIT_CACHE.
  - WAIT_CACHE: hold valid, addr, wdata and wstrb stable until cache_response_in.ready. On the ready cycle, deassert valid and go to IDLE. No new request is taken on that same cycle.
- Exactly one request is outstanding at the cache (IOB is blocking). The meta FIFO therefore decouples only the repacking stage; the response FIFO absorbs downstream backpressure.
- Repacking happens in the cycle after cache_response_in.ready, and the result is pushed to the response FIFO:
  - meta.route.to = stored meta.route.from; meta.route.from = stored meta.route.to.
  - seq_src, seq_id and seq_state are copied unchanged.
  - meta.address is copied unchanged; subclass.buffer is copied; subclass.cmd = CMD_MEM_RESPONSE.
  - Read: data.field[0] = rdata; fields 1..3 are copied from the stored data.
  - Write: data.field[0] = stored wdata, which acts as the acknowledge.
  - The meta FIFO is popped in the same cycle.
- Output timing:
  - response_out is driven from the response FIFO head.
  - Latency from request accept to response_out.valid is 3 cycles plus cache latency, assuming ready is high.
- Credit accounting:
  - Decrement on accept; increment on response_out handshake.
  - Simultaneous accept and handshake leave credit unchanged.
  - Credit never exceeds PENDING_DEPTH and never goes below 0, so the response FIFO can never overflow.
- Status outputs:
  - fifo_response_signals_out.full = (credit == 0); prog_full = (credit <= 2); valid = response_out.valid.
  - done_out = (credit == PENDING_DEPTH) && state == IDLE.
- A cache_response_in.ready outside WAIT_CACHE is ignored and sets an internal sticky error bit, exposed only under the optional feature.

Optional Feature:
- Macro: RESPONSE_HOPS_INC_EN.
- Defined:
  - meta.route.hops on each response = stored hops + 1, saturating at all-ones.
  - A 1-bit sticky protocol_error_out port is added, reset 0. It is set by a stray cache ready.
- Undefined: hops is copied unchanged, no extra port, and a stray ready is ignored silently.

Decomposition:
- PKG_MEMORY: add enum type_response_packer_state {IDLE, ISSUE, WAIT_CACHE}, one-hot, 3 bits.
- PKG_MEMORY: add struct ResponsePackerPending {MemoryPacketMeta meta; MemoryPacketData data; logic is_write;}.
- Reuse MemoryPacket, CacheRequest, CacheRequestIOB, CacheResponseIOB and FIFOStateSignalsOutput unchanged.
- One sub-module, response_packer_fifo: a parameterised synchronous FIFO with width and depth parameters, async active-low reset, and the FIFOStateSignalsOutput output. Instantiate it twice, once for pending meta and once for the response buffer.

Test Plan:
- Single read: from.id_lane = 2, to.id_lane = 5, addr = 0x40, cache ready after 4 cycles with rdata = 0xDEADBEEF.
  -> One response with cmd = CMD_MEM_RESPONSE, to.id_lane = 2, from.id_lane = 5, field[0] = 0xDEADBEEF, valid at cycle 7.
- Write: wstrb = 0xF, wdata = 0x1234.
  -> Response field[0] = 0x1234; cache_request_out fields stay stable through WAIT_CACHE.
- Backpressure: response_out_ready = 0, send 16 back-to-back reads.
  -> request_in_ready = 0 after the 16th accept; full = 1; no response is lost.
  -> Releasing ready drains the 16 responses in order (seq_id 0..15); credit returns to 16 and done_out = 1.
- Simultaneous accept and drain with credit = 1.
  -> Credit stays 1; the FIFO never overflows; ordering is preserved.
- Assert ap_rst_n low in WAIT_CACHE with 3 responses buffered.
  -> All outputs are at reset values in the same cycle; after release, a fresh read completes normally.
- With RESPONSE_HOPS_INC_EN defined:
  -> hops = 3 returns 4; hops = all-ones stays all-ones.
  -> A stray cache ready in IDLE sets protocol_error_out.
